// File: rtl/mips32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_pkg
//  Purpose  : Constants shared between the MIPS32 pipeline and its hazard
//             scoreboard: functional-unit latencies, opcodes, zero register.
//  Revision : 1.0  initial release
// ============================================================================
package mips32_pkg;

    // Cycles from issue until a result can be forwarded
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 4;

    // Hard-wired zero register index
    localparam int REG_ZERO = 0;

    // Opcodes used by the pipeline decoder
    typedef enum logic [5:0] {
        OP_ADD   = 6'b000000,
        OP_SUB   = 6'b000001,
        OP_AND   = 6'b000010,
        OP_OR    = 6'b000011,
        OP_SLT   = 6'b000100,
        OP_MUL   = 6'b000101,
        OP_LW    = 6'b001000,
        OP_SW    = 6'b001001,
        OP_ADDI  = 6'b001010,
        OP_SUBI  = 6'b001011,
        OP_SLTI  = 6'b001100,
        OP_BNEQZ = 6'b001101,
        OP_BEQZ  = 6'b001110,
        OP_HLT   = 6'b111111
    } opcode_t;

endpackage : mips32_pkg
`default_nettype wire

// File: rtl/mips32_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_sat_counter
//  Purpose  : Up-counter that increments on enable and sticks at all-ones.
//  Ports    : clk     - clock, rising edge
//             rst     - asynchronous active-high reset (clears count)
//             i_inc   - increment enable
//             o_count - current count
//  Revision : 1.0  initial release
// ============================================================================
module mips32_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : mips32_sat_counter
`default_nettype wire

// File: rtl/mips32_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_scoreboard
//  Purpose  : Register-hazard scoreboard beside the ID stage. Decides each
//             cycle whether the ID instruction may issue, stalling on RAW,
//             WAW and write-back-port conflicts for variable-latency units.
//  Ports    : clk1, reset            - clock / async active-high reset
//             id_valid               - ID requests issue
//             id_rs/id_rt(+_used)    - source registers and read flags
//             id_rd, id_wr, id_lat   - destination, write flag, unit latency
//             flush                  - taken branch kills ID this cycle
//             stall, issue           - combinational interlock decision
//             busy_vec               - registers with a pending result
//             stall_cnt              - saturating stalled-cycle count
//  Revision : 1.0  initial release
// ============================================================================
module mips32_scoreboard
    import mips32_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int AW      = $clog2(NREG),
    parameter int MAX_LAT = 4,
    parameter int LW      = $clog2(MAX_LAT + 1),
    parameter int CW      = 32
) (
    input  logic            clk1,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_wr,
    input  logic [LW-1:0]   id_lat,
    input  logic            flush,
    output logic            stall,
    output logic            issue,
    output logic [NREG-1:0] busy_vec,
    output logic [CW-1:0]   stall_cnt
);

    logic [NREG-1:0][LW-1:0] w_cnt;        // remaining cycles per register
    logic [MAX_LAT-1:1]      r_wb_slot;    // bit j: write-back j cycles from now
    logic [MAX_LAT-1:1]      w_wb_slot_nxt;
    logic [LW-1:0]           w_lat_eff;
    logic [LW-1:0]           w_lat_m1;
    logic                    w_track;
    logic                    w_raw;
    logic                    w_waw;
    logic                    w_port;
    logic                    w_book;

    // Clamp the requested latency into 1..MAX_LAT
    always_comb begin
        w_lat_eff = id_lat;
        if (id_lat == '0) begin
            w_lat_eff = LW'(1);
        end else if (id_lat > LW'(MAX_LAT)) begin
            w_lat_eff = LW'(MAX_LAT);
        end
    end

    assign w_lat_m1 = w_lat_eff - 1'b1;
    assign w_track  = id_wr && (id_rd != AW'(REG_ZERO));

    assign w_raw = (id_rs_used && (w_cnt[id_rs] != '0)) ||
                   (id_rt_used && (w_cnt[id_rt] != '0));
    assign w_waw = w_track && (w_cnt[id_rd] > w_lat_m1);

    // A MAX_LAT booking can never collide: every older booking has already
    // aged below MAX_LAT, so the top slot needs no storage.
    always_comb begin
        w_port = 1'b0;
        for (int j = 1; j < MAX_LAT; j++) begin
            if (w_lat_eff == LW'(j)) begin
                w_port = w_track && r_wb_slot[j];
            end
        end
    end

    assign stall  = id_valid && !flush && (w_raw || w_waw || w_port);
    assign issue  = id_valid && !flush && !stall;
    assign w_book = issue && w_track;

    // Per-register countdown. A new booking overrides the decrement.
    generate
        for (genvar r = 0; r < NREG; r++) begin : g_reg
            if (r == REG_ZERO) begin : g_zero
                assign w_cnt[r] = '0;
            end else begin : g_track
                logic [LW-1:0] r_cnt;
                always_ff @(posedge clk1 or posedge reset) begin
                    if (reset) begin
                        r_cnt <= '0;
                    end else if (w_book && (id_rd == AW'(r))) begin
                        r_cnt <= w_lat_m1;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                assign w_cnt[r] = r_cnt;
            end
            assign busy_vec[r] = (w_cnt[r] != '0);
        end
    endgenerate

    // A booking at latency L is inserted and aged in the same edge, so after
    // the edge it lands in slot L-1 and the vector always reads "cycles from
    // now" relative to the instruction currently in ID.
    generate
        for (genvar j = 1; j < MAX_LAT; j++) begin : g_slot
            if (j == MAX_LAT - 1) begin : g_top
                assign w_wb_slot_nxt[j] = w_book && (w_lat_eff == LW'(j + 1));
            end else begin : g_mid
                assign w_wb_slot_nxt[j] = r_wb_slot[j + 1] ||
                                          (w_book && (w_lat_eff == LW'(j + 1)));
            end
        end
    endgenerate

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_wb_slot <= '0;
        end else begin
            r_wb_slot <= w_wb_slot_nxt;
        end
    end

    mips32_sat_counter #(
        .WIDTH (CW)
    ) u_stall_cnt (
        .clk     (clk1),
        .rst     (reset),
        .i_inc   (stall),
        .o_count (stall_cnt)
    );

endmodule : mips32_scoreboard
`default_nettype wire

// File: tb/tb_mips32_scoreboard.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mips32_scoreboard
//  Purpose  : Directed scoreboard bench for mips32_scoreboard. The driver
//             pushes one hand-computed expectation per driven cycle; the
//             monitor pops and compares on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips32_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int LW   = 3;
    localparam int CW   = 4;

    logic            clk1 = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [AW-1:0]   id_rs, id_rt, id_rd;
    logic            id_rs_used, id_rt_used, id_wr;
    logic [LW-1:0]   id_lat;
    logic            flush;
    logic            stall, issue;
    logic [NREG-1:0] busy_vec;
    logic [CW-1:0]   stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        stall;
        logic        issue;
        logic [31:0] busy;
        logic [3:0]  scnt;
    } exp_t;

    exp_t exp_q[$];

    mips32_scoreboard #(
        .NREG    (NREG),
        .AW      (AW),
        .MAX_LAT (4),
        .LW      (LW),
        .CW      (CW)
    ) dut (
        .clk1       (clk1),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_rd      (id_rd),
        .id_wr      (id_wr),
        .id_lat     (id_lat),
        .flush      (flush),
        .stall      (stall),
        .issue      (issue),
        .busy_vec   (busy_vec),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation
    always @(negedge clk1) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
            chk({e.name, ".issue"}, {31'd0, issue}, {31'd0, e.issue});
            chk({e.name, ".busy"},  busy_vec, e.busy);
            chk({e.name, ".scnt"},  {28'd0, stall_cnt}, {28'd0, e.scnt});
        end
    end

    // One driven cycle: inputs after the rising edge, expectation pushed.
    // ebit = index of the single expected busy register, or -1 for none.
    task automatic c(input string nm, input bit r, input bit v,
                     input int rs, input bit rsu, input int rt, input bit rtu,
                     input int rd, input bit wr, input int lat, input bit fl,
                     input bit es, input bit ei, input int ebit, input int esc);
        exp_t e;
        @(posedge clk1);
        #1;
        reset      = r;
        id_valid   = v;
        id_rs      = AW'(rs);
        id_rs_used = rsu;
        id_rt      = AW'(rt);
        id_rt_used = rtu;
        id_rd      = AW'(rd);
        id_wr      = wr;
        id_lat     = LW'(lat);
        flush      = fl;
        e.name  = nm;
        e.stall = es;
        e.issue = ei;
        e.busy  = (ebit < 0) ? 32'd0 : (32'd1 << ebit);
        e.scnt  = 4'(esc);
        exp_q.push_back(e);
    endtask

    task automatic rst_cyc(input string nm);
        c(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    endtask

    task automatic idle(input string nm, input int ebit, input int esc);
        c(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ebit, esc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        reset = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_used = 0; id_rt_used = 0; id_wr = 0; id_lat = 0; flush = 0;

        rst_cyc("rst0");

        // Reset mid-stream: MUL R5 in flight, then reset clears everything
        c("A_mul", 0, 1, 1, 1, 0, 0, 5, 1, 4, 0,  0, 1, -1, 0);
        idle("A_busy", 5, 0);
        rst_cyc("A_rst");
        c("A_dep", 0, 1, 5, 1, 0, 0, 0, 0, 1, 0,  0, 1, -1, 0);

        // Back-to-back ALU, consumer reads through rt
        c("B_addi", 0, 1, 1, 1, 0, 0, 2, 1, 1, 0,  0, 1, -1, 0);
        c("B_use",  0, 1, 1, 1, 2, 1, 4, 1, 1, 0,  0, 1, -1, 0);
        idle("B_idle", -1, 0);

        // Load-use: one stall
        rst_cyc("C_rst");
        c("C_lw",  0, 1, 1, 1, 0, 0, 3, 1, 2, 0,  0, 1, -1, 0);
        c("C_s1",  0, 1, 1, 1, 3, 1, 8, 1, 4, 0,  1, 0,  3, 0);
        c("C_iss", 0, 1, 1, 1, 3, 1, 8, 1, 4, 0,  0, 1, -1, 1);
        idle("C_idle", 8, 1);

        // MUL then dependent SUBI: three stalls
        rst_cyc("D_rst");
        c("D_mul", 0, 1, 1, 1, 0, 0, 2, 1, 4, 0,  0, 1, -1, 0);
        c("D_s1",  0, 1, 2, 1, 0, 0, 10, 1, 1, 0, 1, 0,  2, 0);
        c("D_s2",  0, 1, 2, 1, 0, 0, 10, 1, 1, 0, 1, 0,  2, 1);
        c("D_s3",  0, 1, 2, 1, 0, 0, 10, 1, 1, 0, 1, 0,  2, 2);
        c("D_iss", 0, 1, 2, 1, 0, 0, 10, 1, 1, 0, 0, 1, -1, 3);
        idle("D_idle", -1, 3);

        // Write-back port conflict: independent ADDI three cycles after MUL
        rst_cyc("E_rst");
        c("E_mul", 0, 1, 1, 1, 0, 0, 6, 1, 4, 0,  0, 1, -1, 0);
        idle("E_i1", 6, 0);
        idle("E_i2", 6, 0);
        c("E_s1",  0, 1, 1, 1, 0, 0, 7, 1, 1, 0,  1, 0,  6, 0);
        c("E_iss", 0, 1, 1, 1, 0, 0, 7, 1, 1, 0,  0, 1, -1, 1);
        idle("E_idle", -1, 1);

        // WAW: MUL R9 then ADDI R9
        rst_cyc("F_rst");
        c("F_mul", 0, 1, 1, 1, 0, 0, 9, 1, 4, 0,  0, 1, -1, 0);
        c("F_s1",  0, 1, 1, 1, 0, 0, 9, 1, 1, 0,  1, 0,  9, 0);
        c("F_s2",  0, 1, 1, 1, 0, 0, 9, 1, 1, 0,  1, 0,  9, 1);
        c("F_s3",  0, 1, 1, 1, 0, 0, 9, 1, 1, 0,  1, 0,  9, 2);
        c("F_iss", 0, 1, 1, 1, 0, 0, 9, 1, 1, 0,  0, 1, -1, 3);
        idle("F_idle", -1, 3);

        // WAW threshold L-1: LW R9 may issue once cnt[9] drops to 1
        rst_cyc("W_rst");
        c("W_mul", 0, 1, 1, 1, 0, 0, 9, 1, 4, 0,  0, 1, -1, 0);
        c("W_s1",  0, 1, 1, 1, 0, 0, 9, 1, 2, 0,  1, 0,  9, 0);
        c("W_s2",  0, 1, 1, 1, 0, 0, 9, 1, 2, 0,  1, 0,  9, 1);
        c("W_iss", 0, 1, 1, 1, 0, 0, 9, 1, 2, 0,  0, 1,  9, 2);
        idle("W_i1", 9, 2);
        idle("W_i2", -1, 2);

        // R0 never tracked; latency clamps 0->1 and 7->4
        rst_cyc("G_rst");
        c("G_r0w",   0, 1, 1, 1, 0, 0, 0, 1, 4, 0,  0, 1, -1, 0);
        c("G_r0r",   0, 1, 0, 1, 0, 0, 11, 1, 0, 0, 0, 1, -1, 0);
        c("G_lat0",  0, 1, 11, 1, 0, 0, 12, 1, 7, 0, 0, 1, -1, 0);
        c("G_s1",    0, 1, 12, 1, 0, 0, 0, 0, 1, 0,  1, 0, 12, 0);
        c("G_s2",    0, 1, 12, 1, 0, 0, 0, 0, 1, 0,  1, 0, 12, 1);
        c("G_s3",    0, 1, 12, 1, 0, 0, 0, 0, 1, 0,  1, 0, 12, 2);
        c("G_iss",   0, 1, 12, 1, 0, 0, 0, 0, 1, 0,  0, 1, -1, 3);

        // Flush during a RAW stall: no stall/issue, counters keep draining
        rst_cyc("H_rst");
        c("H_mul", 0, 1, 1, 1, 0, 0, 4, 1, 4, 0,  0, 1, -1, 0);
        c("H_s1",  0, 1, 4, 1, 0, 0, 0, 0, 1, 0,  1, 0,  4, 0);
        c("H_fl",  0, 1, 4, 1, 0, 0, 0, 0, 1, 1,  0, 0,  4, 1);
        c("H_s2",  0, 1, 4, 1, 0, 0, 0, 0, 1, 0,  1, 0,  4, 1);
        c("H_iss", 0, 1, 4, 1, 0, 0, 0, 0, 1, 0,  0, 1, -1, 2);

        // Saturation: 18 stall cycles on a 4-bit counter
        rst_cyc("S_rst");
        c("S_mul", 0, 1, 1, 1, 0, 0, 13, 1, 4, 0,  0, 1, -1, 0);
        st = 0;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (j < 3) begin
                    c("S_stl", 0, 1, 13, 1, 0, 0, 13, 1, 4, 0, 1, 0, 13, (st > 15) ? 15 : st);
                    st++;
                end else begin
                    c("S_iss", 0, 1, 13, 1, 0, 0, 13, 1, 4, 0, 0, 1, -1, (st > 15) ? 15 : st);
                end
            end
        end
        idle("S_sat", 13, 15);

        // Drain the expectation queue with a bounded wait
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk1);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mips32_scoreboard
`default_nettype wire
